// File: rtl/enc1553_pkg.sv
// Shared definitions for the 1553 transmit encoder.
// - SYNC_CSW / SYNC_DW : 6-half-bit sync patterns (command/status vs data)
// - WORD_HALF_BITS     : half-bits per encoded word (sync + 16 data + parity)
// - enc_state_e        : serializer FSM states
// - manchester_pack()  : builds the 40-half-bit line pattern, MSB transmitted first
package enc1553_pkg;

    localparam logic [5:0] SYNC_CSW       = 6'b111000;
    localparam logic [5:0] SYNC_DW        = 6'b000111;
    localparam int         WORD_HALF_BITS = 40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } enc_state_e;

    // Pattern bit 39 goes on the line first. Data bit b occupies
    // pattern bits [2b+3:2b+2] as {b, ~b}; parity sits in [1:0].
    function automatic logic [WORD_HALF_BITS-1:0] manchester_pack(
        input logic [15:0] word,
        input logic        csw,
        input logic        parity_odd
    );
        logic [WORD_HALF_BITS-1:0] pat;
        logic                      p;
        p          = parity_odd ? ~^word : ^word;
        pat        = '0;
        pat[39:34] = csw ? SYNC_CSW : SYNC_DW;
        for (int i = 0; i < 16; i++) begin
            pat[2*i+3] = word[i];
            pat[2*i+2] = ~word[i];
        end
        pat[1] = p;
        pat[0] = ~p;
        return pat;
    endfunction

endpackage

// File: rtl/enc1553_word_fifo.sv
// Synchronous word queue for the 1553 encoder.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   flush_i         : empties the queue; blocks any push/pop in the same cycle
//   push_i, din_i   : write request and entry {csw, word}
//   pop_i, dout_o   : read request and head entry (valid while !empty_o)
//   full_o, empty_o : status flags
//   level_o         : number of queued entries
module enc1553_word_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 17
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic                                push_i,
    input  logic [WIDTH-1:0]                    din_i,
    input  logic                                pop_i,
    output logic [WIDTH-1:0]                    dout_o,
    output logic                                full_o,
    output logic                                empty_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH+1);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == LW'(FIFO_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    // A full queue refuses a push even if a pop frees a slot this cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/encoder_1553_tx.sv
// MIL-STD-1553 Manchester-II word encoder (transmit path).
// Words are queued, then serialized back-to-back as one message; once the
// queue drains (or on abort) the line is held idle for at least MIN_GAP
// half-bits before a new message may start.
// Ports:
//   enc_clk, rst_n       : clock, asynchronous active-low reset
//   tx_word, tx_csw      : word and sync type, qualified by tx_valid
//   tx_valid, tx_ready   : push handshake (tx_ready = queue not full)
//   tx_abort             : flush queue and stop the current word
//   tx_data, tx_dval     : registered serial line and line-driven flag
//   tx_busy              : queue non-empty or serializer active or gap running
//   fifo_level           : queued word count
//   words_sent           : completed-word counter (wraps)
module encoder_1553_tx
    import enc1553_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int HALF_BIT_CLKS = 1,
    parameter int MIN_GAP       = 8,
    parameter int PARITY_ODD    = 1
) (
    input  logic                                enc_clk,
    input  logic                                rst_n,
    input  logic [15:0]                         tx_word,
    input  logic                                tx_csw,
    input  logic                                tx_valid,
    output logic                                tx_ready,
    input  logic                                tx_abort,
    output logic                                tx_data,
    output logic                                tx_dval,
    output logic                                tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
    output logic [15:0]                         words_sent
);
    localparam int   PW      = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam int   GAP_CYC = MIN_GAP * HALF_BIT_CLKS;
    localparam int   GW      = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(HALF_BIT_CLKS - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYC);
    localparam logic [5:0]    HB_LAST    = 6'(WORD_HALF_BITS - 1);
    localparam logic          PAR_ODD    = (PARITY_ODD != 0);

    enc_state_e                  state_q, state_d;
    logic [5:0]                  hb_q, hb_d;
    logic [PW-1:0]               presc_q, presc_d;
    logic [GW-1:0]               gap_q, gap_d;
    logic [WORD_HALF_BITS-1:0]   sr_q, sr_d;
    logic [16:0]                 word_q, word_d;
    logic                        tx_data_q, tx_data_d;
    logic                        tx_dval_q, tx_dval_d;
    logic [15:0]                 sent_q;

    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [16:0] fifo_dout;
    logic        word_done, abort_go;

    enc1553_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (17)
    ) u_fifo (
        .clk_i   (enc_clk),
        .rst_ni  (rst_n),
        .flush_i (tx_abort),
        .push_i  (fifo_push),
        .din_i   ({tx_csw, tx_word}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign tx_ready   = !fifo_full;
    assign fifo_push  = tx_valid && !fifo_full && !tx_abort;
    // Abort with nothing queued and nothing on the line must not start a gap.
    assign abort_go   = tx_abort && !(state_q == ST_IDLE && fifo_empty);
    assign tx_data    = tx_data_q;
    assign tx_dval    = tx_dval_q;
    assign tx_busy    = !fifo_empty || (state_q != ST_IDLE);
    assign words_sent = sent_q;

    always_comb begin
        state_d   = state_q;
        hb_d      = hb_q;
        presc_d   = presc_q;
        gap_d     = gap_q;
        sr_d      = sr_q;
        word_d    = word_q;
        fifo_pop  = 1'b0;
        word_done = 1'b0;
        tx_data_d = 1'b0;
        tx_dval_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && gap_q == '0) begin
                    fifo_pop = 1'b1;
                    word_d   = fifo_dout;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sr_d      = manchester_pack(word_q[15:0], word_q[16], PAR_ODD);
                hb_d      = '0;
                presc_d   = '0;
                tx_dval_d = 1'b1;
                tx_data_d = sr_d[WORD_HALF_BITS-1];
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                tx_dval_d = 1'b1;
                tx_data_d = sr_q[WORD_HALF_BITS-1];
                if (presc_q != PRESC_LAST) begin
                    presc_d = presc_q + PW'(1);
                end else begin
                    presc_d = '0;
                    if (hb_q != HB_LAST) begin
                        hb_d      = hb_q + 6'd1;
                        sr_d      = {sr_q[WORD_HALF_BITS-2:0], 1'b0};
                        tx_data_d = sr_d[WORD_HALF_BITS-1];
                    end else begin
                        word_done = 1'b1;
                        if (!fifo_empty) begin
                            // Chain the next queued word with no idle half-bit.
                            fifo_pop  = 1'b1;
                            hb_d      = '0;
                            sr_d      = manchester_pack(fifo_dout[15:0], fifo_dout[16], PAR_ODD);
                            tx_data_d = sr_d[WORD_HALF_BITS-1];
                        end else begin
                            state_d   = ST_GAP;
                            gap_d     = GAP_LOAD;
                            tx_dval_d = 1'b0;
                            tx_data_d = 1'b0;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_q <= GW'(1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides everything, including a word finishing this cycle.
        if (abort_go) begin
            state_d   = ST_GAP;
            gap_d     = GAP_LOAD;
            fifo_pop  = 1'b0;
            word_done = 1'b0;
            tx_data_d = 1'b0;
            tx_dval_d = 1'b0;
        end
    end

    always_ff @(posedge enc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hb_q      <= '0;
            presc_q   <= '0;
            gap_q     <= '0;
            tx_data_q <= 1'b0;
            tx_dval_q <= 1'b0;
            sent_q    <= '0;
        end else begin
            state_q   <= state_d;
            hb_q      <= hb_d;
            presc_q   <= presc_d;
            gap_q     <= gap_d;
            tx_data_q <= tx_data_d;
            tx_dval_q <= tx_dval_d;
            if (word_done) sent_q <= sent_q + 16'd1;
        end
    end

    always_ff @(posedge enc_clk) begin
        sr_q   <= sr_d;
        word_q <= word_d;
    end

endmodule

// File: tb/tb_encoder_1553_tx.sv
module tb_encoder_1553_tx;

    localparam int MIN_GAP = 8;

    logic enc_clk = 1'b0;
    always #5 enc_clk = ~enc_clk;

    // DUT A: default parameters (HALF_BIT_CLKS=1, odd parity)
    logic        rst_n_a, tx_csw_a, tx_valid_a, tx_abort_a;
    logic [15:0] tx_word_a;
    logic        tx_ready_a, tx_data_a, tx_dval_a, tx_busy_a;
    logic [2:0]  level_a;
    logic [15:0] sent_a;

    // DUT B: HALF_BIT_CLKS=2, even parity
    logic        rst_n_b, tx_csw_b, tx_valid_b, tx_abort_b;
    logic [15:0] tx_word_b;
    logic        tx_ready_b, tx_data_b, tx_dval_b, tx_busy_b;
    logic [2:0]  level_b;
    logic [15:0] sent_b;

    encoder_1553_tx #(.FIFO_DEPTH(4), .HALF_BIT_CLKS(1), .MIN_GAP(MIN_GAP), .PARITY_ODD(1)) dut_a (
        .enc_clk(enc_clk), .rst_n(rst_n_a), .tx_word(tx_word_a), .tx_csw(tx_csw_a),
        .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_abort(tx_abort_a),
        .tx_data(tx_data_a), .tx_dval(tx_dval_a), .tx_busy(tx_busy_a),
        .fifo_level(level_a), .words_sent(sent_a)
    );

    encoder_1553_tx #(.FIFO_DEPTH(4), .HALF_BIT_CLKS(2), .MIN_GAP(MIN_GAP), .PARITY_ODD(0)) dut_b (
        .enc_clk(enc_clk), .rst_n(rst_n_b), .tx_word(tx_word_b), .tx_csw(tx_csw_b),
        .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_abort(tx_abort_b),
        .tx_data(tx_data_b), .tx_dval(tx_dval_b), .tx_busy(tx_busy_b),
        .fifo_level(level_b), .words_sent(sent_b)
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Hand-derived line patterns
    localparam logic [39:0] P_F101_CSW_ODD  = 40'b111000_10101010_01010110_01010101_01010110_10;
    localparam logic [39:0] P_0000_DW_ODD   = 40'b000111_01010101_01010101_01010101_01010101_10;
    localparam logic [39:0] P_0000_DW_EVEN  = 40'b000111_01010101_01010101_01010101_01010101_01;
    localparam logic [39:0] P_F101_CSW_EVEN = 40'b111000_10101010_01010110_01010101_01010110_01;

    logic [239:0] bits;
    logic [39:0]  pat, ref_pat;
    int           highs, lows, k, guard, refused, dup_ok;
    logic         saw_full, ready_at_full;
    logic [15:0]  fw [6];
    logic         fc [6];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference encoder for the longer sequences.
    function automatic logic [39:0] exp_pat(input logic [15:0] w, input logic csw, input bit odd);
        logic [39:0] r;
        int ones;
        r = '0;
        ones = 0;
        r[39:34] = csw ? 6'b111000 : 6'b000111;
        for (int i = 0; i < 16; i++) begin
            r[33-2*i] = w[15-i];
            r[32-2*i] = !w[15-i];
            if (w[15-i]) ones++;
        end
        r[1] = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        r[0] = !r[1];
        return r;
    endfunction

    task automatic push_a(input logic [15:0] w, input logic c);
        @(negedge enc_clk);
        tx_word_a = w; tx_csw_a = c; tx_valid_a = 1'b1;
        @(negedge enc_clk);
        tx_valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [15:0] w, input logic c);
        @(negedge enc_clk);
        tx_word_b = w; tx_csw_b = c; tx_valid_b = 1'b1;
        @(negedge enc_clk);
        tx_valid_b = 1'b0;
    endtask

    task automatic wait_dval_a(input string tag);
        int n = 0;
        while (tx_dval_a !== 1'b1 && n < 200) begin @(negedge enc_clk); n++; end
        check(tag, 64'(n < 200), 64'd1);
    endtask

    task automatic wait_dval_b(input string tag);
        int n = 0;
        while (tx_dval_b !== 1'b1 && n < 200) begin @(negedge enc_clk); n++; end
        check(tag, 64'(n < 200), 64'd1);
    endtask

    task automatic collect_a(input int n, output logic [239:0] b, output int h);
        b = '0; h = 0;
        for (int i = 0; i < n; i++) begin
            b[n-1-i] = tx_data_a;
            if (tx_dval_a === 1'b1) h++;
            @(negedge enc_clk);
        end
    endtask

    task automatic collect_b(input int n, output logic [239:0] b, output int h);
        b = '0; h = 0;
        for (int i = 0; i < n; i++) begin
            b[n-1-i] = tx_data_b;
            if (tx_dval_b === 1'b1) h++;
            @(negedge enc_clk);
        end
    endtask

    task automatic count_low_a(input int n, output int l);
        l = 0;
        for (int i = 0; i < n; i++) begin
            if (tx_dval_a === 1'b0 && tx_data_a === 1'b0) l++;
            @(negedge enc_clk);
        end
    endtask

    task automatic count_low_b(input int n, output int l);
        l = 0;
        for (int i = 0; i < n; i++) begin
            if (tx_dval_b === 1'b0 && tx_data_b === 1'b0) l++;
            @(negedge enc_clk);
        end
    endtask

    // Every half-bit of DUT B spans two samples; fold pairs into one pattern.
    task automatic decimate_b(input logic [239:0] b, output logic [39:0] p, output int ok);
        ok = 1;
        for (int j = 0; j < 40; j++) begin
            p[39-j] = b[79-2*j];
            if (b[79-2*j] !== b[78-2*j]) ok = 0;
        end
    endtask

    initial begin
        rst_n_a = 1'b0; tx_valid_a = 1'b0; tx_abort_a = 1'b0; tx_word_a = '0; tx_csw_a = 1'b0;
        rst_n_b = 1'b0; tx_valid_b = 1'b0; tx_abort_b = 1'b0; tx_word_b = '0; tx_csw_b = 1'b0;
        repeat (3) @(negedge enc_clk);

        // Reset state
        check("rst_data",  64'(tx_data_a),  64'd0);
        check("rst_dval",  64'(tx_dval_a),  64'd0);
        check("rst_ready", 64'(tx_ready_a), 64'd1);
        check("rst_busy",  64'(tx_busy_a),  64'd0);
        check("rst_level", 64'(level_a),    64'd0);
        check("rst_sent",  64'(sent_a),     64'd0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        @(negedge enc_clk);

        // Single command word 0xF101 and latency E0 -> E2
        push_a(16'hF101, 1'b1);
        check("w1_level_push", 64'(level_a), 64'd1);
        check("w1_lat_e0", 64'(tx_dval_a), 64'd0);
        @(negedge enc_clk);
        check("w1_lat_e1", 64'(tx_dval_a), 64'd0);
        check("w1_level_pop", 64'(level_a), 64'd0);
        @(negedge enc_clk);
        check("w1_lat_e2", 64'(tx_dval_a), 64'd1);
        collect_a(40, bits, highs);
        check("w1_pattern", 64'(bits[39:0]), 64'(P_F101_CSW_ODD));
        check("w1_dval_len", 64'(highs), 64'd40);
        count_low_a(MIN_GAP, lows);
        check("w1_gap", 64'(lows), 64'(MIN_GAP));
        check("w1_sent", 64'(sent_a), 64'd1);
        check("w1_idle_busy", 64'(tx_busy_a), 64'd0);

        // Data word 0x0000
        push_a(16'h0000, 1'b0);
        wait_dval_a("w2_start");
        collect_a(40, bits, highs);
        check("w2_pattern", 64'(bits[39:0]), 64'(P_0000_DW_ODD));
        count_low_a(MIN_GAP, lows);
        check("w2_gap", 64'(lows), 64'(MIN_GAP));
        check("w2_sent", 64'(sent_a), 64'd2);

        // Three words back to back
        @(negedge enc_clk);
        tx_word_a = 16'hF101; tx_csw_a = 1'b1; tx_valid_a = 1'b1;
        @(negedge enc_clk);
        tx_word_a = 16'h0000; tx_csw_a = 1'b0;
        @(negedge enc_clk);
        tx_word_a = 16'hF101; tx_csw_a = 1'b0;
        @(negedge enc_clk);
        tx_valid_a = 1'b0;
        wait_dval_a("b2b_start");
        collect_a(120, bits, highs);
        check("b2b_dval_len", 64'(highs), 64'd120);
        check("b2b_word0", 64'(bits[119:80]), 64'(P_F101_CSW_ODD));
        check("b2b_word1", 64'(bits[79:40]),  64'(P_0000_DW_ODD));
        ref_pat = {6'b000111, P_F101_CSW_ODD[33:0]};
        check("b2b_word2", 64'(bits[39:0]), 64'(ref_pat));
        count_low_a(MIN_GAP, lows);
        check("b2b_gap", 64'(lows), 64'(MIN_GAP));
        check("b2b_sent", 64'(sent_a), 64'd5);

        // Flow control: five words offered while the first is on the line
        fw[0] = 16'h1234; fc[0] = 1'b1;
        fw[1] = 16'hABCD; fc[1] = 1'b0;
        fw[2] = 16'h0F0F; fc[2] = 1'b1;
        fw[3] = 16'h8001; fc[3] = 1'b0;
        fw[4] = 16'h7FFE; fc[4] = 1'b0;
        fw[5] = 16'hFFFF; fc[5] = 1'b1;
        push_a(fw[0], fc[0]);
        wait_dval_a("fc_start");
        k = 1; guard = 0; refused = 0; saw_full = 1'b0; ready_at_full = 1'b1;
        fork
            collect_a(240, bits, highs);
            begin
                while (k <= 5 && guard < 400) begin
                    tx_word_a = fw[k]; tx_csw_a = fc[k]; tx_valid_a = 1'b1;
                    if (level_a == 3'd4 && !saw_full) begin
                        saw_full = 1'b1;
                        ready_at_full = tx_ready_a;
                    end
                    if (tx_ready_a) k++;
                    else refused++;
                    @(negedge enc_clk);
                    guard++;
                end
                tx_valid_a = 1'b0;
            end
        join
        check("fc_all_pushed", 64'(k), 64'd6);
        check("fc_saw_full", 64'(saw_full), 64'd1);
        check("fc_ready_at_full", 64'(ready_at_full), 64'd0);
        check("fc_refused", 64'(refused > 0), 64'd1);
        check("fc_dval_len", 64'(highs), 64'd240);
        for (int j = 0; j < 6; j++) begin
            check($sformatf("fc_word%0d", j), 64'(bits[239-40*j -: 40]), 64'(exp_pat(fw[j], fc[j], 1'b1)));
        end
        count_low_a(MIN_GAP, lows);
        check("fc_gap", 64'(lows), 64'(MIN_GAP));
        check("fc_sent", 64'(sent_a), 64'd11);

        // Abort at half-bit 20 with two words queued
        push_a(16'hAAAA, 1'b1);
        wait_dval_a("ab_start");
        tx_word_a = 16'h5555; tx_csw_a = 1'b0; tx_valid_a = 1'b1;
        @(negedge enc_clk);
        tx_word_a = 16'h0F0F;
        @(negedge enc_clk);
        tx_valid_a = 1'b0;
        repeat (18) @(negedge enc_clk);
        check("ab_level_before", 64'(level_a), 64'd2);
        check("ab_dval_before", 64'(tx_dval_a), 64'd1);
        tx_abort_a = 1'b1; tx_word_a = 16'h1111; tx_csw_a = 1'b1; tx_valid_a = 1'b1;
        @(negedge enc_clk);
        tx_abort_a = 1'b0;
        check("ab_dval", 64'(tx_dval_a), 64'd0);
        check("ab_data", 64'(tx_data_a), 64'd0);
        check("ab_level", 64'(level_a), 64'd0);
        check("ab_sent", 64'(sent_a), 64'd11);
        check("ab_busy", 64'(tx_busy_a), 64'd1);
        tx_word_a = 16'hC3C3; tx_csw_a = 1'b1; tx_valid_a = 1'b1;
        @(negedge enc_clk);
        tx_valid_a = 1'b0;
        lows = 1;
        while (tx_dval_a !== 1'b1 && lows < 50) begin lows++; @(negedge enc_clk); end
        check("ab_gap_to_sync", 64'(lows), 64'(MIN_GAP + 2));
        collect_a(40, bits, highs);
        check("ab_next_pattern", 64'(bits[39:0]), 64'(exp_pat(16'hC3C3, 1'b1, 1'b1)));
        count_low_a(MIN_GAP, lows);
        check("ab_next_gap", 64'(lows), 64'(MIN_GAP));
        check("ab_next_sent", 64'(sent_a), 64'd12);
        check("ab_next_level", 64'(level_a), 64'd0);

        // Abort while idle and empty does nothing
        @(negedge enc_clk);
        tx_abort_a = 1'b1;
        @(negedge enc_clk);
        tx_abort_a = 1'b0;
        check("idle_abort_busy", 64'(tx_busy_a), 64'd0);
        push_a(16'h0001, 1'b0);
        check("idle_abort_e0", 64'(tx_dval_a), 64'd0);
        @(negedge enc_clk);
        @(negedge enc_clk);
        check("idle_abort_e2", 64'(tx_dval_a), 64'd1);
        collect_a(40, bits, highs);
        check("idle_abort_pattern", 64'(bits[39:0]), 64'(exp_pat(16'h0001, 1'b0, 1'b1)));
        count_low_a(MIN_GAP, lows);
        check("idle_abort_sent", 64'(sent_a), 64'd13);

        // DUT B: two-cycle half-bits, even parity
        push_b(16'h0000, 1'b0);
        wait_dval_b("b_w1_start");
        collect_b(80, bits, highs);
        decimate_b(bits, pat, dup_ok);
        check("b_w1_halfbit_len", 64'(dup_ok), 64'd1);
        check("b_w1_pattern", 64'(pat), 64'(P_0000_DW_EVEN));
        check("b_w1_dval_len", 64'(highs), 64'd80);
        count_low_b(2*MIN_GAP, lows);
        check("b_w1_gap", 64'(lows), 64'(2*MIN_GAP));
        check("b_w1_sent", 64'(sent_b), 64'd1);

        // Asynchronous reset in the middle of a word
        push_b(16'hF101, 1'b1);
        wait_dval_b("b_rst_start");
        repeat (20) @(negedge enc_clk);
        #2 rst_n_b = 1'b0;
        #1;
        check("b_rst_data",  64'(tx_data_b),  64'd0);
        check("b_rst_dval",  64'(tx_dval_b),  64'd0);
        check("b_rst_ready", 64'(tx_ready_b), 64'd1);
        check("b_rst_busy",  64'(tx_busy_b),  64'd0);
        check("b_rst_level", 64'(level_b),    64'd0);
        check("b_rst_sent",  64'(sent_b),     64'd0);
        @(negedge enc_clk);
        rst_n_b = 1'b1;
        push_b(16'hF101, 1'b1);
        wait_dval_b("b_w2_start");
        collect_b(80, bits, highs);
        decimate_b(bits, pat, dup_ok);
        check("b_w2_halfbit_len", 64'(dup_ok), 64'd1);
        check("b_w2_pattern", 64'(pat), 64'(P_F101_CSW_EVEN));
        count_low_b(2*MIN_GAP, lows);
        check("b_w2_gap", 64'(lows), 64'(2*MIN_GAP));
        check("b_w2_sent", 64'(sent_b), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
